// File: rtl/spi_master_ctrl.sv
`timescale 1ns/1ps
// spi_master_ctrl: SPI master with an internal SCLK divider, all four CPOL/CPHA
// modes, MSB/LSB-first order, multi-lane data, decoded active-low selects and
// multi-word bursts with the select held low between words.
//
// Handshake: a word is transferred on a rising clk edge where tx_valid and
// tx_ready are both high; tx_data/tx_last must be stable while tx_valid is
// high. rx_valid is a one-cycle pulse with no backpressure.
module spi_master_ctrl #(
  parameter int WORD_WIDTH = 8,
  parameter int LANES      = 1,
  parameter int SS_WIDTH   = 4,
  parameter int DIV_WIDTH  = 8,
  localparam int SEL_W     = $clog2((SS_WIDTH > 2) ? SS_WIDTH : 2)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_cpol,
  input  logic                  cfg_cpha,
  input  logic                  cfg_lsb_first,
  input  logic [DIV_WIDTH-1:0]  cfg_div,
  input  logic [SEL_W-1:0]      cfg_ss_sel,
  input  logic                  abort,
  input  logic                  tx_valid,
  input  logic [WORD_WIDTH-1:0] tx_data,
  input  logic                  tx_last,
  output logic                  tx_ready,
  output logic                  rx_valid,
  output logic [WORD_WIDTH-1:0] rx_data,
  output logic                  busy,
  output logic                  sclk,
  output logic [LANES-1:0]      sd_out,
  input  logic [LANES-1:0]      sd_in,
  output logic [SS_WIDTH-1:0]   ss_n,
  output logic [2:0]            dbg_state_o
);

  localparam int N  = WORD_WIDTH / LANES;
  localparam int EW = $clog2(2 * N);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * N - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_WAIT  = 3'd3,
    S_TRAIL = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  state_t                state_q;
  logic [DIV_WIDTH-1:0]  div_cnt_q;
  logic [EW-1:0]         edge_cnt_q;
  logic [WORD_WIDTH-1:0] tx_sh_q;
  logic [WORD_WIDTH-1:0] rx_sh_q;
  logic [WORD_WIDTH-1:0] rx_data_q;
  logic                  rx_valid_q;
  logic                  sclk_q;
  logic [SS_WIDTH-1:0]   ss_n_q;
  logic [LANES-1:0]      sd_out_q;
  logic                  last_q;
  logic                  cpol_q;
  logic                  cpha_q;
  logic                  lsb_q;
  logic [DIV_WIDTH-1:0]  div_q;

  // Lane chunk presented on sd_out for a given shift-register value.
  function automatic logic [LANES-1:0] chunk(input logic [WORD_WIDTH-1:0] v, input logic lsb);
    chunk = lsb ? v[LANES-1:0] : v[WORD_WIDTH-1 -: LANES];
  endfunction

  // Advance the tx shift register by one chunk in the selected order.
  function automatic logic [WORD_WIDTH-1:0] shift_w(input logic [WORD_WIDTH-1:0] v, input logic lsb);
    shift_w = lsb ? (v >> LANES) : (v << LANES);
  endfunction

  // One-hot-low select; an out-of-range index leaves every line high.
  function automatic logic [SS_WIDTH-1:0] ss_decode(input logic [SEL_W-1:0] sel);
    ss_decode = '1;
    for (int i = 0; i < SS_WIDTH; i++) begin
      if (sel == SEL_W'(i)) ss_decode[i] = 1'b0;
    end
  endfunction

  logic                  hp_done;
  logic                  lead_edge;
  logic                  last_edge;
  logic                  eff_cpha;
  logic                  eff_lsb;
  logic                  sample_now;
  logic                  drive_now;
  logic [WORD_WIDTH-1:0] rx_next;

  // Edge classification and receive shift; IDLE accepts use the live cfg.
  assign hp_done    = (div_cnt_q == div_q);
  assign lead_edge  = ~edge_cnt_q[0];
  assign last_edge  = (edge_cnt_q == LAST_EDGE);
  assign eff_cpha   = (state_q == S_IDLE) ? cfg_cpha : cpha_q;
  assign eff_lsb    = (state_q == S_IDLE) ? cfg_lsb_first : lsb_q;
  assign sample_now = cpha_q ? ~lead_edge : lead_edge;
  assign drive_now  = cpha_q ? lead_edge : (~lead_edge & ~last_edge);
  assign rx_next    = lsb_q ? ((rx_sh_q >> LANES) | (WORD_WIDTH'(sd_in) << (WORD_WIDTH - LANES)))
                            : ((rx_sh_q << LANES) | WORD_WIDTH'(sd_in));

  // Transfer FSM with divider, edge counter and all registered pin outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      sclk_q     <= 1'b0;
      ss_n_q     <= '1;
      sd_out_q   <= '0;
      last_q     <= 1'b0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      div_q      <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        S_IDLE, S_WAIT: begin
          div_cnt_q <= '0;
          if (state_q == S_IDLE) sclk_q <= cfg_cpol;
          // A word on offer wins over abort in WAIT so an accepted word is never lost.
          if (tx_valid) begin
            if (state_q == S_IDLE) begin
              cpol_q <= cfg_cpol;
              cpha_q <= cfg_cpha;
              lsb_q  <= cfg_lsb_first;
              div_q  <= cfg_div;
              ss_n_q <= ss_decode(cfg_ss_sel);
            end
            last_q     <= tx_last;
            edge_cnt_q <= '0;
            if (!eff_cpha) begin
              sd_out_q <= chunk(tx_data, eff_lsb);
              tx_sh_q  <= shift_w(tx_data, eff_lsb);
            end else begin
              tx_sh_q  <= tx_data;
            end
            state_q <= S_LEAD;
          end else if ((state_q == S_WAIT) && abort) begin
            ss_n_q  <= '1;
            state_q <= S_GAP;
          end
        end
        S_LEAD, S_SHIFT, S_TRAIL: begin
          if (abort) begin
            ss_n_q    <= '1;
            sclk_q    <= cpol_q;
            div_cnt_q <= '0;
            state_q   <= S_GAP;
          end else if (!hp_done) begin
            div_cnt_q <= div_cnt_q + DIV_WIDTH'(1);
          end else begin
            div_cnt_q <= '0;
            if (state_q == S_LEAD) begin
              state_q <= S_SHIFT;
            end else if (state_q == S_TRAIL) begin
              ss_n_q  <= '1;
              state_q <= S_GAP;
            end else begin
              sclk_q     <= ~sclk_q;
              edge_cnt_q <= edge_cnt_q + EW'(1);
              if (sample_now) rx_sh_q <= rx_next;
              if (drive_now) begin
                sd_out_q <= chunk(tx_sh_q, lsb_q);
                tx_sh_q  <= shift_w(tx_sh_q, lsb_q);
              end
              if (last_edge) begin
                rx_data_q  <= sample_now ? rx_next : rx_sh_q;
                rx_valid_q <= 1'b1;
                edge_cnt_q <= '0;
                state_q    <= last_q ? S_TRAIL : S_WAIT;
              end
            end
          end
        end
        S_GAP: begin
          if (hp_done) begin
            div_cnt_q <= '0;
            state_q   <= S_IDLE;
          end else begin
            div_cnt_q <= div_cnt_q + DIV_WIDTH'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_ready    = (state_q == S_IDLE) || (state_q == S_WAIT);
  assign busy        = (state_q != S_IDLE);
  assign rx_valid    = rx_valid_q;
  assign rx_data     = rx_data_q;
  assign sclk        = sclk_q;
  assign sd_out      = sd_out_q;
  assign ss_n        = ss_n_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
`timescale 1ns/1ps
// tb_spi_master_ctrl: scenario tasks against an SPI slave model and a word
// scoreboard; a second 4-lane instance covers multi-lane operation.
module tb_spi_master_ctrl;
  localparam int W = 8, SSW = 4, DW = 8, SELW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic cfg_cpol, cfg_cpha, cfg_lsb_first, abort;
  logic [DW-1:0] cfg_div;
  logic [SELW-1:0] cfg_ss_sel;
  logic tx_valid, tx_last, tx_ready, rx_valid, busy, sclk;
  logic [W-1:0] tx_data, rx_data;
  logic [0:0] sd_out, sd_in;
  logic [SSW-1:0] ss_n;
  logic [2:0] dbg_state;

  logic tx_valid4, tx_last4, tx_ready4, rx_valid4, busy4, sclk4;
  logic [W-1:0] tx_data4, rx_data4;
  logic [3:0] sd_out4, sd_in4;
  logic [SSW-1:0] ss_n4;
  logic [2:0] dbg_state4;

  bit loop_en, cpha_m, lsb_m;
  logic sd_slave;
  assign sd_in  = loop_en ? sd_out : sd_slave;
  assign sd_in4 = sd_out4;

  spi_master_ctrl #(.WORD_WIDTH(W), .LANES(1), .SS_WIDTH(SSW), .DIV_WIDTH(DW)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
    .cfg_lsb_first(cfg_lsb_first), .cfg_div(cfg_div), .cfg_ss_sel(cfg_ss_sel),
    .abort(abort), .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy),
    .sclk(sclk), .sd_out(sd_out), .sd_in(sd_in), .ss_n(ss_n), .dbg_state_o(dbg_state));

  spi_master_ctrl #(.WORD_WIDTH(W), .LANES(4), .SS_WIDTH(SSW), .DIV_WIDTH(DW)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
    .cfg_lsb_first(cfg_lsb_first), .cfg_div(cfg_div), .cfg_ss_sel(cfg_ss_sel),
    .abort(abort), .tx_valid(tx_valid4), .tx_data(tx_data4), .tx_last(tx_last4),
    .tx_ready(tx_ready4), .rx_valid(rx_valid4), .rx_data(rx_data4), .busy(busy4),
    .sclk(sclk4), .sd_out(sd_out4), .sd_in(sd_in4), .ss_n(ss_n4), .dbg_state_o(dbg_state4));

  int n_checks = 0;
  int n_fail = 0;

  // ---------------- scoreboard + monitor ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  int cyc = 0, edges = 0, rises = 0, n_rxv = 0, ss_rise = 0;
  int ss_low[SSW] = '{default: 0};
  int hp_min = 1000, hp_max = 0, last_tog = 0;
  bit tog_valid = 0;
  logic prev_sclk = 1'b0, prev_ss_all = 1'b1, prev_busy = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (rx_valid) begin
        n_rxv++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rx_unexpected: got %h, required no word", rx_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (rx_data !== mon_exp) begin
            n_fail++; $display("FAIL rx_word: got %h, required %h", rx_data, mon_exp);
          end
        end
      end
      for (int i = 0; i < SSW; i++) if (ss_n[i] === 1'b0) ss_low[i]++;
      if ((&ss_n) && !prev_ss_all) ss_rise++;
      prev_ss_all = &ss_n;
      if (busy && !prev_busy) begin hp_min = 1000; hp_max = 0; tog_valid = 0; end
      prev_busy = busy;
      if ((sclk !== prev_sclk) && busy) begin
        edges++;
        if (sclk) rises++;
        if (tog_valid) begin
          if (cyc - last_tog < hp_min) hp_min = cyc - last_tog;
          if (cyc - last_tog > hp_max) hp_max = cyc - last_tog;
        end
        tog_valid = 1;
        last_tog = cyc;
      end
      prev_sclk = sclk;
    end
  end

  // ---------------- SPI slave model (1 lane) ----------------
  // Edge k (1-based) within a word: odd = leading. The slave samples MOSI and
  // drives MISO at the edges dictated by CPHA, bit j at position pos(j).
  logic [W-1:0] s_word = '0, s_rx = '0;
  int s_edges = 0;
  logic s_prev = 1'b0;

  function automatic int pos(input int j, input bit lsb);
    return lsb ? j : (W - 1 - j);
  endfunction

  always @(negedge clk) begin
    if (&ss_n) begin
      s_edges = 0;
      s_prev = sclk;
      sd_slave = s_word[pos(0, lsb_m)];
    end else if (sclk !== s_prev) begin
      int k, js, jd;
      s_prev = sclk;
      s_edges++;
      k = ((s_edges - 1) % (2 * W)) + 1;
      js = (k - 1) / 2;
      jd = cpha_m ? (k - 1) / 2 : k / 2;
      if ((cpha_m ? (k % 2 == 0) : (k % 2 == 1)) && js < W) s_rx[pos(js, lsb_m)] = sd_out[0];
      if ((cpha_m ? (k % 2 == 1) : (k % 2 == 0)) && jd < W) sd_slave = s_word[pos(jd, lsb_m)];
    end
  end

  // ---------------- 4-lane monitor ----------------
  logic [3:0] chunk4_q[$];
  int rx4_cnt = 0;
  logic [W-1:0] rx4_word = '0;
  logic prev_sclk4 = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid4) begin rx4_cnt++; rx4_word = rx_data4; end
      if (sclk4 && !prev_sclk4 && busy4) chunk4_q.push_back(sd_out4);
      prev_sclk4 = sclk4;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_cfg(input bit cpol, input bit cpha, input bit lsb, input int dv, input int sel);
    @(negedge clk);
    cfg_cpol = cpol; cfg_cpha = cpha; cfg_lsb_first = lsb;
    cfg_div = DW'(dv); cfg_ss_sel = SELW'(sel);
    cpha_m = cpha; lsb_m = lsb;
  endtask

  task automatic send_word(input logic [W-1:0] d, input logic l);
    int t = 0;
    @(negedge clk);
    tx_valid = 1'b1; tx_data = d; tx_last = l;
    while (!tx_ready && t < 2000) begin @(negedge clk); t++; end
    n_checks++;
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL send_timeout: tx_ready=%b, required 1", tx_ready); end
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 5000) begin @(negedge clk); t++; end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_timeout: busy=%b, required 0", busy); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks += 9;
    if (sclk !== 1'b0) begin n_fail++; $display("FAIL rst_sclk: got %b, required 0", sclk); end
    if (ss_n !== 4'hF) begin n_fail++; $display("FAIL rst_ss_n: got %h, required f", ss_n); end
    if (sd_out !== 1'b0) begin n_fail++; $display("FAIL rst_sd_out: got %b, required 0", sd_out); end
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_tx_ready: got %b, required 1", tx_ready); end
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rx_valid: got %b, required 0", rx_valid); end
    if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rst_rx_data: got %h, required 00", rx_data); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, required 0", busy); end
    if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d, required idle(0)", dbg_state); end
    if (ss_n4 !== 4'hF || busy4 !== 1'b0 || dbg_state4 !== 3'd0) begin
      n_fail++; $display("FAIL rst_dut4: ss_n=%h busy=%b, required f/0", ss_n4, busy4);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mode0_loop();
    int b_rise, b_edge, b_ss0, b_rxv;
    set_cfg(0, 0, 0, 0, 0); loop_en = 1;
    repeat (2) @(negedge clk);
    b_rise = rises; b_edge = edges; b_ss0 = ss_low[0]; b_rxv = n_rxv;
    exp_q.push_back(8'hA5);
    send_word(8'hA5, 1'b1);
    wait_idle();
    n_checks += 7;
    if (rises - b_rise != 8) begin n_fail++; $display("FAIL m0_rises: got %0d, required 8", rises - b_rise); end
    if (edges - b_edge != 16) begin n_fail++; $display("FAIL m0_edges: got %0d, required 16", edges - b_edge); end
    if (ss_low[0] - b_ss0 != 18) begin n_fail++; $display("FAIL m0_ss_low: got %0d, required 18", ss_low[0] - b_ss0); end
    if (hp_min != 1 || hp_max != 1) begin n_fail++; $display("FAIL m0_hp: got %0d..%0d, required 1", hp_min, hp_max); end
    if (n_rxv - b_rxv != 1) begin n_fail++; $display("FAIL m0_rxv: got %0d, required 1", n_rxv - b_rxv); end
    if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL m0_rx_data: got %h, required a5", rx_data); end
    if (s_rx !== 8'hA5) begin n_fail++; $display("FAIL m0_mosi: got %h, required a5", s_rx); end
  endtask

  task automatic test_mode3_slave();
    int b_ss[SSW];
    set_cfg(1, 1, 0, 2, 2); loop_en = 0; s_word = 8'hC3;
    repeat (3) @(negedge clk);
    n_checks++;
    if (sclk !== 1'b1) begin n_fail++; $display("FAIL m3_idle_sclk: got %b, required 1", sclk); end
    for (int i = 0; i < SSW; i++) b_ss[i] = ss_low[i];
    exp_q.push_back(8'hC3);
    send_word(8'h3C, 1'b1);
    wait_idle();
    n_checks += 6;
    if (ss_low[2] - b_ss[2] != 54) begin n_fail++; $display("FAIL m3_ss2_low: got %0d, required 54", ss_low[2] - b_ss[2]); end
    if ((ss_low[0] - b_ss[0]) + (ss_low[1] - b_ss[1]) + (ss_low[3] - b_ss[3]) != 0) begin
      n_fail++; $display("FAIL m3_other_ss: got %0d low cycles, required 0", (ss_low[0] - b_ss[0]) + (ss_low[1] - b_ss[1]) + (ss_low[3] - b_ss[3]));
    end
    if (hp_min != 3 || hp_max != 3) begin n_fail++; $display("FAIL m3_hp: got %0d..%0d, required 3", hp_min, hp_max); end
    if (rx_data !== 8'hC3) begin n_fail++; $display("FAIL m3_rx_data: got %h, required c3", rx_data); end
    if (s_rx !== 8'h3C) begin n_fail++; $display("FAIL m3_mosi: got %h, required 3c", s_rx); end
    if (sclk !== 1'b1) begin n_fail++; $display("FAIL m3_end_sclk: got %b, required 1", sclk); end
  endtask

  task automatic test_back_to_back();
    int b_rise_ss, b_rxv, t;
    set_cfg(0, 0, 0, 1, 1); loop_en = 1;
    repeat (2) @(negedge clk);
    b_rise_ss = ss_rise; b_rxv = n_rxv;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    send_word(8'h11, 1'b0);
    t = 0;
    while (!(busy && tx_ready) && t < 500) begin @(negedge clk); t++; end
    n_checks++;
    if (!(busy && tx_ready)) begin n_fail++; $display("FAIL burst_wait_state: busy=%b tx_ready=%b, required 1/1", busy, tx_ready); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (sclk !== 1'b0 || ss_n[1] !== 1'b0) begin
        n_fail++; $display("FAIL burst_wait_hold: sclk=%b ss_n1=%b, required 0/0", sclk, ss_n[1]);
      end
    end
    send_word(8'h22, 1'b0);
    send_word(8'h33, 1'b1);
    wait_idle();
    n_checks += 3;
    if (n_rxv - b_rxv != 3) begin n_fail++; $display("FAIL burst_rxv: got %0d, required 3", n_rxv - b_rxv); end
    if (ss_rise - b_rise_ss != 1) begin n_fail++; $display("FAIL burst_ss_release: got %0d, required 1", ss_rise - b_rise_ss); end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL burst_pending: got %0d words left, required 0", exp_q.size()); end
  endtask

  task automatic test_lanes4();
    logic [W-1:0] w;
    logic [3:0] ec;
    int base, b_rx, t;
    for (int it = 0; it < 2; it++) begin
      w = (it == 0) ? 8'h5A : W'($urandom_range(0, 255));
      set_cfg(0, 0, (it == 0), 0, 3);
      base = chunk4_q.size(); b_rx = rx4_cnt;
      @(negedge clk);
      tx_valid4 = 1'b1; tx_data4 = w; tx_last4 = 1'b1;
      @(posedge clk); #1;
      tx_valid4 = 1'b0;
      t = 0;
      while (busy4 && t < 500) begin @(negedge clk); t++; end
      n_checks += 3;
      if (busy4 !== 1'b0) begin n_fail++; $display("FAIL l4_timeout: busy=%b, required 0", busy4); end
      if (chunk4_q.size() - base != 2) begin
        n_fail++; $display("FAIL l4_chunk_count: got %0d, required 2", chunk4_q.size() - base);
      end else begin
        for (int j = 0; j < 2; j++) begin
          ec = (it == 0) ? 4'((w >> (4 * j)) & 8'h0F) : 4'((w >> (W - 4 * (j + 1))) & 8'h0F);
          n_checks++;
          if (chunk4_q[base + j] !== ec) begin n_fail++; $display("FAIL l4_chunk%0d: got %h, required %h", j, chunk4_q[base + j], ec); end
        end
      end
      if (rx4_cnt - b_rx != 1 || rx4_word !== w) begin
        n_fail++; $display("FAIL l4_rx: got %h (%0d pulses), required %h (1 pulse)", rx4_word, rx4_cnt - b_rx, w);
      end
    end
  endtask

  task automatic test_abort();
    int b_rxv, b_edge, t;
    logic [W-1:0] w;
    set_cfg(0, 0, 0, 2, 0); loop_en = 1;
    repeat (2) @(negedge clk);
    b_rxv = n_rxv; b_edge = edges;
    send_word(8'hFF, 1'b1);
    t = 0;
    while (edges - b_edge < 3 && t < 500) begin @(negedge clk); t++; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_checks += 4;
    if (ss_n !== 4'hF) begin n_fail++; $display("FAIL abort_ss_n: got %h, required f", ss_n); end
    if (sclk !== 1'b0) begin n_fail++; $display("FAIL abort_sclk: got %b, required 0", sclk); end
    if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL abort_gap_ready: got %b, required 0", tx_ready); end
    if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_gap_busy: got %b, required 1", busy); end
    wait_idle();
    n_checks += 2;
    if (n_rxv != b_rxv) begin n_fail++; $display("FAIL abort_rxv: got %0d pulses, required 0", n_rxv - b_rxv); end
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready_after: got %b, required 1", tx_ready); end
    w = W'($urandom_range(0, 255));
    exp_q.push_back(w);
    send_word(w, 1'b1);
    wait_idle();
    n_checks++;
    if (n_rxv - b_rxv != 1 || rx_data !== w) begin
      n_fail++; $display("FAIL abort_recover: got %h (%0d pulses), required %h (1 pulse)", rx_data, n_rxv - b_rxv, w);
    end
  endtask

  task automatic test_reset_mid();
    int b_edge, t;
    logic [W-1:0] w;
    set_cfg(0, 0, 0, 3, 0); loop_en = 1;
    repeat (2) @(negedge clk);
    b_edge = edges;
    send_word(8'h96, 1'b1);
    t = 0;
    while (edges - b_edge < 4 && t < 500) begin @(negedge clk); t++; end
    #2 rst_n = 1'b0;
    #1;
    n_checks += 7;
    if (sclk !== 1'b0) begin n_fail++; $display("FAIL mrst_sclk: got %b, required 0", sclk); end
    if (ss_n !== 4'hF) begin n_fail++; $display("FAIL mrst_ss_n: got %h, required f", ss_n); end
    if (sd_out !== 1'b0) begin n_fail++; $display("FAIL mrst_sd_out: got %b, required 0", sd_out); end
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL mrst_tx_ready: got %b, required 1", tx_ready); end
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_rx_valid: got %b, required 0", rx_valid); end
    if (rx_data !== 8'h00) begin n_fail++; $display("FAIL mrst_rx_data: got %h, required 00", rx_data); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mrst_busy: got %b, required 0", busy); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    w = W'($urandom_range(0, 255));
    exp_q.push_back(w);
    send_word(w, 1'b1);
    wait_idle();
    n_checks++;
    if (rx_data !== w) begin n_fail++; $display("FAIL mrst_recover: got %h, required %h", rx_data, w); end
  endtask

  task automatic test_random_modes();
    bit cpol, cpha, lsb;
    int dv, sel, b_ss;
    logic [W-1:0] tw, sw;
    for (int it = 0; it < 6; it++) begin
      cpol = 1'($urandom_range(0, 1)); cpha = 1'($urandom_range(0, 1)); lsb = 1'($urandom_range(0, 1));
      dv = $urandom_range(0, 3); sel = $urandom_range(0, SSW - 1);
      tw = W'($urandom_range(0, 255)); sw = W'($urandom_range(0, 255));
      set_cfg(cpol, cpha, lsb, dv, sel); loop_en = 0; s_word = sw;
      repeat (2) @(negedge clk);
      n_checks++;
      if (sclk !== cpol) begin n_fail++; $display("FAIL rnd_idle_sclk: got %b, required %b", sclk, cpol); end
      b_ss = ss_low[sel];
      exp_q.push_back(sw);
      send_word(tw, 1'b1);
      wait_idle();
      n_checks += 4;
      if (s_rx !== tw) begin n_fail++; $display("FAIL rnd_mosi: mode %0d%0d lsb %0d got %h, required %h", cpol, cpha, lsb, s_rx, tw); end
      if (rx_data !== sw) begin n_fail++; $display("FAIL rnd_miso: mode %0d%0d lsb %0d got %h, required %h", cpol, cpha, lsb, rx_data, sw); end
      if (ss_low[sel] - b_ss != 18 * (dv + 1)) begin
        n_fail++; $display("FAIL rnd_ss_low: got %0d, required %0d", ss_low[sel] - b_ss, 18 * (dv + 1));
      end
      if (hp_min != dv + 1 || hp_max != dv + 1) begin
        n_fail++; $display("FAIL rnd_hp: got %0d..%0d, required %0d", hp_min, hp_max, dv + 1);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    cfg_cpol = 0; cfg_cpha = 0; cfg_lsb_first = 0; cfg_div = '0; cfg_ss_sel = '0; abort = 0;
    tx_valid = 0; tx_data = '0; tx_last = 0;
    tx_valid4 = 0; tx_data4 = '0; tx_last4 = 0;
    loop_en = 1; cpha_m = 0; lsb_m = 0;
    test_reset();
    test_mode0_loop();
    test_mode3_slave();
    test_back_to_back();
    test_lanes4();
    test_abort();
    test_reset_mid();
    test_random_modes();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
